// File: rtl/uart_pkg.sv
// uart_pkg: shared UART baud codes, rate table and divisor arithmetic
package uart_pkg;
  typedef enum logic [2:0] {
    BAUD_300, BAUD_1200, BAUD_4800, BAUD_9600,
    BAUD_19200, BAUD_38400, BAUD_57600, BAUD_115200
  } baud_code_t;
  localparam int unsigned BAUD_RATES [8] = '{300, 1200, 4800, 9600, 19200, 38400, 57600, 115200};
  function automatic longint calc_div(longint clk_hz, longint rate, longint os);
    return (clk_hz + rate * os / 2) / (rate * os);
  endfunction
endpackage

// File: rtl/baud_divisor_rom.sv
// baud_divisor_rom: baud code to clock divisor, table fixed at elaboration
module baud_divisor_rom
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int OVERSAMPLE  = 16,
  parameter int CNT_WIDTH   = 16
) (
  input  logic [2:0]           code,
  output logic [CNT_WIDTH-1:0] div
);
  logic [CNT_WIDTH-1:0] div_table [8];
  for (genvar i = 0; i < 8; i++) begin : g_div
    localparam longint D = calc_div(CLK_FREQ_HZ, BAUD_RATES[i], OVERSAMPLE);
    if (D < 2 || D > (longint'(1) << CNT_WIDTH) - 1) begin : g_bad
      $error("baud divisor out of range for CNT_WIDTH");
    end
    assign div_table[i] = CNT_WIDTH'(D);
  end
  assign div = div_table[code];
endmodule

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: oversample, mid-bit and bit tick generator with run-time baud select
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int OVERSAMPLE  = 16,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [2:0]           baud_select,
  input  logic                 resync,
  output logic                 sample_tick,
  output logic                 mid_bit_tick,
  output logic                 bit_tick,
  output logic                 baud_changed,
  output logic [CNT_WIDTH-1:0] divisor_out
);
  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] OS_MAX = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] OS_MID = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_WIDTH-1:0] DIV_RST =
    CNT_WIDTH'(calc_div(CLK_FREQ_HZ, BAUD_RATES[0], OVERSAMPLE));
  if (OVERSAMPLE % 2 != 0 || OVERSAMPLE < 4 || OVERSAMPLE > 32) begin : g_bad_os
    $error("OVERSAMPLE must be even and within 4..32");
  end
  logic [2:0]           sel_q;
  logic [CNT_WIDTH-1:0] div_cnt;
  logic [CNT_WIDTH-1:0] new_div;
  logic [OS_W-1:0]      os_cnt;
  baud_divisor_rom #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ),
    .OVERSAMPLE (OVERSAMPLE),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_rom (
    .code(baud_select),
    .div (new_div)
  );
  // A baud change wins over enable/resync so the new divisor is never missed
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sel_q        <= '0;
      divisor_out  <= DIV_RST;
      div_cnt      <= '0;
      os_cnt       <= '0;
      sample_tick  <= 1'b0;
      mid_bit_tick <= 1'b0;
      bit_tick     <= 1'b0;
      baud_changed <= 1'b0;
    end else begin
      sample_tick  <= 1'b0;
      mid_bit_tick <= 1'b0;
      bit_tick     <= 1'b0;
      baud_changed <= baud_select != sel_q;
      if (baud_select != sel_q) begin
        sel_q       <= baud_select;
        divisor_out <= new_div;
        div_cnt     <= '0;
        os_cnt      <= '0;
      end else if (!enable || resync) begin
        div_cnt <= '0;
        os_cnt  <= '0;
      end else if (div_cnt == divisor_out - CNT_WIDTH'(1)) begin
        div_cnt      <= '0;
        sample_tick  <= 1'b1;
        os_cnt       <= os_cnt == OS_MAX ? '0 : os_cnt + OS_W'(1);
        mid_bit_tick <= os_cnt == OS_MID;
        bit_tick     <= os_cnt == OS_MAX;
      end else begin
        div_cnt <= div_cnt + CNT_WIDTH'(1);
      end
    end
endmodule

// File: tb/tb_baud_tick_gen.sv
// tb_baud_tick_gen: directed and random stimulus against an elapsed-time tick model
module tb_baud_tick_gen;
  localparam int OS = 16;
  logic clk = 1'b0, reset = 1'b1, enable = 1'b0, resync = 1'b0;
  logic [2:0] baud_select = '0;
  logic sample_tick, mid_bit_tick, bit_tick, baud_changed;
  logic [15:0] divisor_out;
  int total = 0, bad = 0;
  int divtab [8];
  int edge_n = 0, start = 0, d_exp = 0, el = 0;
  logic [2:0] sel_m = '0;
  logic chg = 1'b0;
  baud_tick_gen #(
    .CLK_FREQ_HZ(100_000_000),
    .OVERSAMPLE (OS),
    .CNT_WIDTH  (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .baud_select (baud_select),
    .resync      (resync),
    .sample_tick (sample_tick),
    .mid_bit_tick(mid_bit_tick),
    .bit_tick    (bit_tick),
    .baud_changed(baud_changed),
    .divisor_out (divisor_out)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  // Ticks are a pure function of clocks elapsed since the last clearing event
  task automatic step();
    int p;
    @(posedge clk);
    edge_n++;
    chg = 1'b0;
    if (reset) begin
      sel_m = '0;
      d_exp = divtab[0];
      start = edge_n;
    end else begin
      chg = baud_select != sel_m;
      if (chg) begin
        sel_m = baud_select;
        d_exp = divtab[sel_m];
        start = edge_n;
      end else if (!enable || resync) start = edge_n;
    end
    el = edge_n - start;
    p = d_exp * OS;
    #1;
    chk("sample_tick", sample_tick, el > 0 && el % d_exp == 0);
    chk("mid_bit_tick", mid_bit_tick, el > 0 && el % p == p / 2);
    chk("bit_tick", bit_tick, el > 0 && el % p == 0);
    chk("baud_changed", baud_changed, chg);
    chk("divisor_out", divisor_out, d_exp);
  endtask
  task automatic run(input int n);
    repeat (n) step();
  endtask
  initial begin
    int rates [8];
    int n;
    rates = '{300, 1200, 4800, 9600, 19200, 38400, 57600, 115200};
    for (int i = 0; i < 8; i++) divtab[i] = $rtoi(100.0e6 / (rates[i] * 16.0) + 0.5);
    run(3);
    chk("rst_divisor", divisor_out, 20833);
    reset = 1'b0;
    enable = 1'b1;
    baud_select = 3'd3;
    step();
    chk("div_9600", divisor_out, 651);
    run(21000);
    baud_select = 3'd7;
    step();
    chk("div_115200", divisor_out, 54);
    run(2000);
    baud_select = 3'd3;
    run(651 * 5 + 100);
    baud_select = 3'd6;
    step();
    chk("div_57600", divisor_out, 109);
    run(2000);
    baud_select = 3'd7;
    run(54 * 9 + 10);
    resync = 1'b1;
    step();
    resync = 1'b0;
    run(54 * 16 * 2 + 10);
    run(300);
    enable = 1'b0;
    run(100);
    enable = 1'b1;
    run(2000);
    repeat (15) begin
      baud_select = 3'($urandom_range(5, 7));
      n = $urandom_range(300, 2500);
      repeat (n) begin
        resync = $urandom_range(0, 399) == 0;
        enable = $urandom_range(0, 299) != 0;
        step();
      end
    end
    resync = 1'b0;
    enable = 1'b1;
    baud_select = 3'd7;
    run(500);
    #3 reset = 1'b1;
    #1;
    chk("arst_sample", sample_tick, 0);
    chk("arst_mid", mid_bit_tick, 0);
    chk("arst_bit", bit_tick, 0);
    chk("arst_changed", baud_changed, 0);
    chk("arst_divisor", divisor_out, 20833);
    run(2);
    reset = 1'b0;
    baud_select = 3'd5;
    step();
    chk("div_38400", divisor_out, 163);
    run(2000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
